// File: rtl/sar_logic_if.sv
// Signal bundle between the SAR controller and the analog front end:
// conversion handshake, comparator request/decision and both cap-DAC control words.
interface sar_logic_if #(
  parameter int unsigned ADC_BITS = 8
);

  logic                start;
  logic                comp_valid;
  logic                comp_out;
  logic                sample_en;
  logic                comp_req;
  logic [ADC_BITS-1:1] dacp_h;
  logic [ADC_BITS-1:1] dacp_l;
  logic [ADC_BITS-1:1] dacn_h;
  logic [ADC_BITS-1:1] dacn_l;
  logic [ADC_BITS-1:0] dout;
  logic                dout_valid;
  logic                busy;
  logic                timeout;

  // Controller side
  modport master (
    input  start,
    input  comp_valid,
    input  comp_out,
    output sample_en,
    output comp_req,
    output dacp_h,
    output dacp_l,
    output dacn_h,
    output dacn_l,
    output dout,
    output dout_valid,
    output busy,
    output timeout
  );

  // Analog model / requester side
  modport slave (
    output start,
    output comp_valid,
    output comp_out,
    input  sample_en,
    input  comp_req,
    input  dacp_h,
    input  dacp_l,
    input  dacn_h,
    input  dacn_l,
    input  dout,
    input  dout_valid,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/sar_logic.sv
// Successive-approximation controller: samples, requests one comparison per bit,
// switches the differential three-level cap DACs and publishes the code with a valid pulse.
module sar_logic #(
  parameter int unsigned ADC_BITS      = 8,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COMP_TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  sar_logic_if.master bus
);

  localparam int unsigned DAC_W   = ADC_BITS - 1;
  localparam int unsigned K_W     = $clog2(ADC_BITS);
  localparam int unsigned CNT_W   = (COMP_TIMEOUT > 255) ? $clog2(COMP_TIMEOUT + 1) : 8;
  localparam int unsigned TO_LAST = (COMP_TIMEOUT == 0) ? 0 : COMP_TIMEOUT - 1;
  localparam logic [K_W-1:0] K_MSB = K_W'(ADC_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    COMP   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ADC_BITS-1:0] result_q, result_d;

  logic                sample_en_q, sample_en_d;
  logic                comp_req_q, comp_req_d;
  logic [DAC_W:1]      dacp_h_q, dacp_h_d;
  logic [DAC_W:1]      dacp_l_q, dacp_l_d;
  logic [DAC_W:1]      dacn_h_q, dacn_h_d;
  logic [DAC_W:1]      dacn_l_q, dacn_l_d;
  logic [ADC_BITS-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic sample_last;
  logic settle_last;
  logic to_expire;
  logic decide;
  logic dec_bit;
  logic lsb;

  // A single counter times sampling, settling and the comparator wait; it restarts on every state change.
  assign sample_last = (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));
  assign settle_last = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
  assign to_expire   = (COMP_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
  assign decide      = bus.comp_valid || to_expire;
  // A timed-out comparison resolves to 0; a real decision always wins the tie.
  assign dec_bit     = bus.comp_valid & bus.comp_out;
  assign lsb         = (k_q == '0);

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      result_q     <= '0;
      sample_en_q  <= 1'b0;
      comp_req_q   <= 1'b0;
      dacp_h_q     <= '0;
      dacp_l_q     <= '0;
      dacn_h_q     <= '0;
      dacn_l_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      result_q     <= result_d;
      sample_en_q  <= sample_en_d;
      comp_req_q   <= comp_req_d;
      dacp_h_q     <= dacp_h_d;
      dacp_l_q     <= dacp_l_d;
      dacn_h_q     <= dacn_h_d;
      dacn_l_q     <= dacn_l_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next state, timing counter, bit pointer and working result
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SAMPLE;
          cnt_d    = '0;
          k_d      = K_MSB;
          result_d = '0;
        end
      end
      SAMPLE: begin
        if (sample_last) begin
          state_d = COMP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COMP: begin
        if (decide) begin
          result_d[k_q] = dec_bit;
          cnt_d         = '0;
          state_d       = lsb ? IDLE : SETTLE;
        end else if (COMP_TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (settle_last) begin
          state_d = COMP;
          cnt_d   = '0;
          k_d     = k_q - K_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    sample_en_d  = 1'b0;
    comp_req_d   = 1'b0;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    timeout_d    = timeout_q;
    dout_d       = dout_q;
    dacp_h_d     = dacp_h_q;
    dacp_l_d     = dacp_l_q;
    dacn_h_d     = dacn_h_q;
    dacn_l_d     = dacn_l_q;
    case (state_q)
      IDLE: begin
        dacp_h_d = '0;
        dacp_l_d = '0;
        dacn_h_d = '0;
        dacn_l_d = '0;
        if (bus.start) begin
          busy_d      = 1'b1;
          timeout_d   = 1'b0;
          sample_en_d = 1'b1;
        end
      end
      SAMPLE: begin
        sample_en_d = !sample_last;
        comp_req_d  = sample_last;
      end
      COMP: begin
        if (!decide) begin
          comp_req_d = 1'b1;
        end else begin
          if (!bus.comp_valid) begin
            timeout_d = 1'b1;
          end
          if (lsb) begin
            dacp_h_d     = '0;
            dacp_l_d     = '0;
            dacn_h_d     = '0;
            dacn_l_d     = '0;
            dout_d       = {result_q[ADC_BITS-1:1], dec_bit};
            dout_valid_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            // vop > von: pull the positive side down and the negative side up
            dacp_h_d[k_q] = !dec_bit;
            dacp_l_d[k_q] = dec_bit;
            dacn_h_d[k_q] = dec_bit;
            dacn_l_d[k_q] = !dec_bit;
          end
        end
      end
      SETTLE: begin
        comp_req_d = settle_last;
      end
      default: ;
    endcase
  end

  assign bus.sample_en  = sample_en_q;
  assign bus.comp_req   = comp_req_q;
  assign bus.dacp_h     = dacp_h_q;
  assign bus.dacp_l     = dacp_l_q;
  assign bus.dacn_h     = dacn_h_q;
  assign bus.dacn_l     = dacn_l_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic: directed conversions against a scripted comparator, with a
// scoreboard of expected codes drained by a monitor on every dout_valid pulse.
module tb_sar_logic;

  localparam int unsigned ADC_BITS = 8;

  typedef struct {
    logic [7:0] dout;
    logic       to;
    int         s0;
    int         lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  int   passed   = 0;
  int   total    = 0;
  int   dv_count = 0;
  exp_t sbq[$];
  exp_t m;

  // Comparator script: decisions MSB first, response delay, optional silent MSB
  logic [7:0] resp_pat   = 8'h00;
  int         resp_delay = 0;
  bit         silent_msb = 1'b0;
  int         rises      = 0;
  int         wait_cnt   = 0;
  int         req_cycles = 0;
  logic       prev_req   = 1'b0;

  sar_logic_if #(.ADC_BITS(ADC_BITS)) bus ();

  sar_logic #(
    .ADC_BITS     (ADC_BITS),
    .SAMPLE_CYCLES(2),
    .SETTLE_CYCLES(1),
    .COMP_TIMEOUT (4)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({bus.sample_en, bus.comp_req, bus.dacp_h, bus.dacp_l, bus.dacn_h, bus.dacn_l,
                bus.dout, bus.dout_valid, bus.busy, bus.timeout});
  endfunction

  function automatic logic [63:0] all_dac();
    return 64'({bus.dacp_h, bus.dacp_l, bus.dacn_h, bus.dacn_l});
  endfunction

  // Returns at 1 time unit after the edge that opens cycle n of the conversion begun at s0
  task automatic goto_cycle(input int s0, input int n);
    while (cyc < s0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after an edge (that cycle is cycle 0); returns in cycle 1
  task automatic start_conv(input logic [7:0] pat, input int delay, input bit silent,
                            input bit push, input logic [7:0] exp_dout, input bit exp_to,
                            input int exp_lat, output int s0);
    exp_t e;
    resp_pat   = pat;
    resp_delay = delay;
    silent_msb = silent;
    rises      = 0;
    req_cycles = 0;
    s0         = cyc;
    if (push) begin
      e.dout = exp_dout;
      e.to   = exp_to;
      e.s0   = cyc;
      e.lat  = exp_lat;
      sbq.push_back(e);
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (dv_count < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("done_wait", 64'(dv_count), 64'(target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int s1;
    bus.start      = 1'b0;
    bus.comp_valid = 1'b0;
    bus.comp_out   = 1'b0;

    fork
      // Comparator responder
      forever begin
        @(negedge clk);
        if (bus.comp_req && !prev_req) begin
          rises++;
          wait_cnt = 0;
        end
        if (bus.comp_req) begin
          req_cycles++;
          bus.comp_valid = !(silent_msb && rises == 1) && (wait_cnt == resp_delay) &&
                           (rises >= 1) && (rises <= 8);
          bus.comp_out   = (rises >= 1 && rises <= 8) ? resp_pat[3'(8 - rises)] : 1'b0;
          wait_cnt++;
        end else begin
          bus.comp_valid = 1'b0;
          bus.comp_out   = 1'b0;
        end
        prev_req = bus.comp_req;
      end
      // Scoreboard monitor
      forever begin
        @(negedge clk);
        if (bus.dout_valid === 1'b1) begin
          dv_count++;
          if (sbq.size() == 0) begin
            chk("unexpected_dout_valid", 64'd1, 64'd0);
          end else begin
            m = sbq.pop_front();
            chk("sb_dout", 64'(bus.dout), 64'(m.dout));
            chk("sb_timeout", 64'(bus.timeout), 64'(m.to));
            chk("sb_latency", 64'(cyc - m.s0), 64'(m.lat));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", all_out(), 64'd0);
    end
    @(posedge clk);
    #1;

    // Reset in cycle 9 aborts the conversion without a result
    start_conv(8'h99, 0, 1'b0, 1'b0, 8'h00, 1'b0, 0, s0);
    goto_cycle(s0, 9);
    @(negedge clk);
    chk("busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    goto_cycle(s0, 10);
    @(negedge clk);
    chk("reset_mid_outputs", all_out(), 64'd0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("reset_no_dout_valid", 64'(dv_count), 64'd0);

    // 0xA5, every decision in the first comp_req cycle
    start_conv(8'hA5, 0, 1'b0, 1'b1, 8'hA5, 1'b0, 18, s0);
    @(negedge clk);
    chk("busy_c1", 64'(bus.busy), 64'd1);
    chk("sample_en_c1", 64'(bus.sample_en), 64'd1);
    chk("comp_req_c1", 64'(bus.comp_req), 64'd0);
    goto_cycle(s0, 2);
    @(negedge clk);
    chk("sample_en_c2", 64'(bus.sample_en), 64'd1);
    chk("comp_req_c2", 64'(bus.comp_req), 64'd0);
    goto_cycle(s0, 3);
    @(negedge clk);
    chk("comp_req_c3", 64'(bus.comp_req), 64'd1);
    chk("sample_en_c3", 64'(bus.sample_en), 64'd0);
    goto_cycle(s0, 4);
    @(negedge clk);
    chk("dac7_after_first", 64'({bus.dacp_h[7], bus.dacp_l[7], bus.dacn_h[7], bus.dacn_l[7]}),
        64'd6);
    chk("comp_req_c4", 64'(bus.comp_req), 64'd0);
    goto_cycle(s0, 6);
    @(negedge clk);
    chk("dacp6_after_second", 64'({bus.dacp_h[6], bus.dacp_l[6]}), 64'd2);
    goto_cycle(s0, 17);
    @(negedge clk);
    chk("dacs_c17", all_dac(), 64'({7'b0101101, 7'b1010010, 7'b1010010, 7'b0101101}));
    chk("dout_hold_c17", 64'(bus.dout), 64'd0);
    goto_cycle(s0, 18);
    @(negedge clk);
    chk("dacs_c18", all_dac(), 64'd0);
    chk("busy_c18", 64'(bus.busy), 64'd0);
    wait_done(1);
    chk("req_cycles_fast", 64'(req_cycles), 64'd8);

    // 0x3C, every decision 3 cycles late (lands on the timeout edge; comp_valid wins)
    start_conv(8'h3C, 3, 1'b0, 1'b1, 8'h3C, 1'b0, 42, s0);
    goto_cycle(s0, 6);
    @(negedge clk);
    chk("comp_req_slow_c6", 64'(bus.comp_req), 64'd1);
    goto_cycle(s0, 7);
    @(negedge clk);
    chk("comp_req_slow_c7", 64'(bus.comp_req), 64'd0);
    wait_done(2);
    chk("req_cycles_slow", 64'(req_cycles), 64'd32);

    // Silent comparator on the MSB: timeout takes it as 0
    start_conv(8'hFF, 0, 1'b1, 1'b1, 8'h7F, 1'b1, 21, s0);
    goto_cycle(s0, 6);
    @(negedge clk);
    chk("comp_req_to_c6", 64'(bus.comp_req), 64'd1);
    chk("timeout_c6", 64'(bus.timeout), 64'd0);
    goto_cycle(s0, 7);
    @(negedge clk);
    chk("comp_req_to_c7", 64'(bus.comp_req), 64'd0);
    chk("timeout_c7", 64'(bus.timeout), 64'd1);
    wait_done(3);
    chk("timeout_sticky_idle", 64'(bus.timeout), 64'd1);

    // Starts while busy are ignored; accepting a start clears timeout
    start_conv(8'h5A, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 18, s0);
    @(negedge clk);
    chk("timeout_cleared_c1", 64'(bus.timeout), 64'd0);
    goto_cycle(s0, 5);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    goto_cycle(s0, 10);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(4);
    repeat (25) @(posedge clk);
    #1;
    chk("single_dout_valid", 64'(dv_count), 64'd4);
    chk("busy_after_ignored", 64'(bus.busy), 64'd0);

    // Back-to-back: start held in the dout_valid cycle
    start_conv(8'h81, 0, 1'b0, 1'b1, 8'h81, 1'b0, 18, s0);
    goto_cycle(s0, 18);
    start_conv(8'h42, 0, 1'b0, 1'b1, 8'h42, 1'b0, 18, s1);
    @(negedge clk);
    chk("b2b_sample_en_c19", 64'(bus.sample_en), 64'd1);
    chk("b2b_busy_c19", 64'(bus.busy), 64'd1);
    wait_done(6);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
